// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID opcode, carries controls through ID/EX, EX/MEM, MEM/WB,
// raises load-use stalls, squashes on EX redirect, selects EX forwarding and counts stalls/flushes.
module pipelined_control_unit #(
  parameter int REG_W        = 5,
  parameter bit ENABLE_UPPER = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_flush,
  output logic             stall,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic             ex_illegal,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [REG_W-1:0] wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t            w_dec;
  ctrl_t            w_id_ctrl;
  logic             w_dec_rs1;
  logic             w_dec_rs2;
  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_stall;

  ctrl_t            r_ex;
  logic [REG_W-1:0] r_ex_rs1;
  logic [REG_W-1:0] r_ex_rs2;
  logic [REG_W-1:0] r_ex_rd;
  logic             r_mem_memread;
  logic             r_mem_memwrite;
  logic             r_mem_regwrite;
  logic             r_mem_memtoreg;
  logic [REG_W-1:0] r_mem_rd;
  logic             r_wb_regwrite;
  logic             r_wb_memtoreg;
  logic [REG_W-1:0] r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // EX/MEM beats MEM/WB because it holds the younger producer.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             m_rw,
    input logic [REG_W-1:0] m_rd,
    input logic             w_rw,
    input logic [REG_W-1:0] w_rd
  );
    if (m_rw && (m_rd != REG_ZERO) && (m_rd == rs)) begin
      return 2'b10;
    end else if (w_rw && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // ID-stage opcode decode; invalid slots become an all-zero bubble.
  always_comb begin
    w_dec     = CTRL_NOP;
    w_dec_rs1 = 1'b0;
    w_dec_rs2 = 1'b0;
    case (id_opcode)
      OP_R:    begin w_dec.aluop = 2'b10; w_dec.regwrite = 1'b1; w_dec_rs1 = 1'b1; w_dec_rs2 = 1'b1; end
      OP_I:    begin w_dec.alusrc = 1'b1; w_dec.aluop = 2'b10; w_dec.regwrite = 1'b1; w_dec_rs1 = 1'b1; end
      OP_LW:   begin
        w_dec.alusrc   = 1'b1;
        w_dec.memread  = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.regwrite = 1'b1;
        w_dec_rs1      = 1'b1;
      end
      OP_SW:   begin w_dec.alusrc = 1'b1; w_dec.memwrite = 1'b1; w_dec_rs1 = 1'b1; w_dec_rs2 = 1'b1; end
      OP_BR:   begin w_dec.branch = 1'b1; w_dec.aluop = 2'b01; w_dec_rs1 = 1'b1; w_dec_rs2 = 1'b1; end
      OP_JAL:  begin w_dec.jal = 1'b1; w_dec.regwrite = 1'b1; end
      OP_JALR: begin w_dec.jalr = 1'b1; w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1; w_dec_rs1 = 1'b1; end
      OP_LUI, OP_AUIPC: begin
        if (ENABLE_UPPER) begin
          w_dec.alusrc   = 1'b1;
          w_dec.aluop    = 2'b11;
          w_dec.regwrite = 1'b1;
        end else begin
          w_dec.illegal  = 1'b1;
        end
      end
      default: w_dec.illegal = 1'b1;
    endcase
    w_dec.regwrite = w_dec.regwrite & (id_rd != REG_ZERO);
    w_id_ctrl      = id_valid ? w_dec : CTRL_NOP;
    w_use_rs1      = id_valid & w_dec_rs1;
    w_use_rs2      = id_valid & w_dec_rs2;
  end

  assign w_stall = id_valid & r_ex.memread & (r_ex_rd != REG_ZERO) &
                   ((w_use_rs1 & (r_ex_rd == id_rs1)) | (w_use_rs2 & (r_ex_rd == id_rs2)));

  // ID/EX: flush and stall both insert a bubble; ID is held upstream on stall.
  always_ff @(posedge clk) begin
    if (!reset || ex_flush || w_stall) begin
      r_ex     <= CTRL_NOP;
      r_ex_rs1 <= REG_ZERO;
      r_ex_rs2 <= REG_ZERO;
      r_ex_rd  <= REG_ZERO;
    end else begin
      r_ex     <= w_id_ctrl;
      r_ex_rs1 <= id_valid ? id_rs1 : REG_ZERO;
      r_ex_rs2 <= id_valid ? id_rs2 : REG_ZERO;
      r_ex_rd  <= id_valid ? id_rd : REG_ZERO;
    end
  end

  // EX/MEM and MEM/WB always advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_memread  <= 1'b0;
      r_mem_memwrite <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_mem_rd       <= REG_ZERO;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_rd        <= REG_ZERO;
    end else begin
      r_mem_memread  <= r_ex.memread;
      r_mem_memwrite <= r_ex.memwrite;
      r_mem_regwrite <= r_ex.regwrite;
      r_mem_memtoreg <= r_ex.memtoreg;
      r_mem_rd       <= r_ex_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      r_wb_rd        <= r_mem_rd;
    end
  end

  // Saturating stall/flush counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= CNT_ZERO;
      r_flush_cnt <= CNT_ZERO;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (ex_flush && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign stall        = w_stall;
  assign fwd_a        = fwd_sel(r_ex_rs1, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
  assign fwd_b        = fwd_sel(r_ex_rs2, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
  assign ex_alusrc    = r_ex.alusrc;
  assign ex_aluop     = r_ex.aluop;
  assign ex_branch    = r_ex.branch;
  assign ex_jal       = r_ex.jal;
  assign ex_jalr      = r_ex.jalr;
  assign ex_illegal   = r_ex.illegal;
  assign mem_memread  = r_mem_memread;
  assign mem_memwrite = r_mem_memwrite;
  assign mem_rd       = r_mem_rd;
  assign wb_regwrite  = r_wb_regwrite;
  assign wb_memtoreg  = r_wb_memtoreg;
  assign wb_rd        = r_wb_rd;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: one instance with upper-immediate decode and wide
// counters, one without upper decode and 2-bit counters, both fed the same instruction stream.
module tb_pipelined_control_unit;
  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;

  logic clk = 1'b0;
  logic reset, id_valid, ex_flush;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic st1, alusrc1, br1, jal1, jalr1, ill1, mrd1, mwr1, wrw1, wmt1;
  logic [1:0] aluop1, fa1, fb1;
  logic [4:0] mrdx1, wrd1;
  logic [15:0] sc_o1, fc_o1;
  logic st2, alusrc2, br2, jal2, jalr2, ill2, mrd2, mwr2, wrw2, wmt2;
  logic [1:0] aluop2, fa2, fb2;
  logic [4:0] mrdx2, wrd2;
  logic [1:0] sc_o2, fc_o2;

  always #5 clk = ~clk;

  pipelined_control_unit #(.REG_W(5), .ENABLE_UPPER(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush), .stall(st1), .ex_alusrc(alusrc1),
    .ex_aluop(aluop1), .ex_branch(br1), .ex_jal(jal1), .ex_jalr(jalr1), .ex_illegal(ill1),
    .fwd_a(fa1), .fwd_b(fb1), .mem_memread(mrd1), .mem_memwrite(mwr1), .mem_rd(mrdx1),
    .wb_regwrite(wrw1), .wb_memtoreg(wmt1), .wb_rd(wrd1), .stall_cnt(sc_o1), .flush_cnt(fc_o1));

  pipelined_control_unit #(.REG_W(5), .ENABLE_UPPER(1'b0), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush), .stall(st2), .ex_alusrc(alusrc2),
    .ex_aluop(aluop2), .ex_branch(br2), .ex_jal(jal2), .ex_jalr(jalr2), .ex_illegal(ill2),
    .fwd_a(fa2), .fwd_b(fb2), .mem_memread(mrd2), .mem_memwrite(mwr2), .mem_rd(mrdx2),
    .wb_regwrite(wrw2), .wb_memtoreg(wmt2), .wb_rd(wrd2), .stall_cnt(sc_o2), .flush_cnt(fc_o2));

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rd;
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e2;
  } ent_t;

  ent_t q_ex[$];
  exp_t ex1, mem1, wb1, ex2, mem2, wb2;
  int checks = 0;
  int errors = 0;
  int sc1, fc1, sc2, fc2;

  function automatic exp_t dec(input logic v, input logic [6:0] op, input logic [4:0] rd,
                               input logic upper);
    exp_t e;
    e = '0;
    if (v) begin
      case (op)
        R:   begin e.aluop = 2'b10; e.regwrite = 1'b1; end
        I:   begin e.alusrc = 1'b1; e.aluop = 2'b10; e.regwrite = 1'b1; end
        LW:  begin e.alusrc = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; end
        SW:  begin e.alusrc = 1'b1; e.memwrite = 1'b1; end
        BR:  begin e.branch = 1'b1; e.aluop = 2'b01; end
        JAL: begin e.jal = 1'b1; e.regwrite = 1'b1; end
        JLR: begin e.jalr = 1'b1; e.alusrc = 1'b1; e.regwrite = 1'b1; end
        LUI, AUI: begin
          if (upper) begin e.alusrc = 1'b1; e.aluop = 2'b11; e.regwrite = 1'b1; end
          else e.illegal = 1'b1;
        end
        default: e.illegal = 1'b1;
      endcase
      if (rd == 5'd0) e.regwrite = 1'b0;
      e.rd = rd;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ex1"}, 32'({alusrc1, aluop1, br1, jal1, jalr1, ill1}),
        32'({ex1.alusrc, ex1.aluop, ex1.branch, ex1.jal, ex1.jalr, ex1.illegal}));
    chk({tag, ".ex2"}, 32'({alusrc2, aluop2, br2, jal2, jalr2, ill2}),
        32'({ex2.alusrc, ex2.aluop, ex2.branch, ex2.jal, ex2.jalr, ex2.illegal}));
    chk({tag, ".mem1"}, 32'({mrd1, mwr1, mrdx1}), 32'({mem1.memread, mem1.memwrite, mem1.rd}));
    chk({tag, ".mem2"}, 32'({mrd2, mwr2, mrdx2}), 32'({mem2.memread, mem2.memwrite, mem2.rd}));
    chk({tag, ".wb1"}, 32'({wrw1, wmt1, wrd1}), 32'({wb1.regwrite, wb1.memtoreg, wb1.rd}));
    chk({tag, ".wb2"}, 32'({wrw2, wmt2, wrd2}), 32'({wb2.regwrite, wb2.memtoreg, wb2.rd}));
    chk({tag, ".stall_cnt"}, 32'(sc_o1), 32'(sc1));
    chk({tag, ".flush_cnt"}, 32'(fc_o1), 32'(fc1));
    chk({tag, ".stall_cnt_sat"}, 32'(sc_o2), 32'(sc2));
    chk({tag, ".flush_cnt_sat"}, 32'(fc_o2), 32'(fc2));
  endtask

  task automatic check_comb(input string tag, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb);
    chk({tag, ".stall"}, 32'(st1), 32'(st));
    chk({tag, ".stall_sat"}, 32'(st2), 32'(st));
    chk({tag, ".fwd1"}, 32'({fa1, fb1}), 32'({fa, fb}));
    chk({tag, ".fwd2"}, 32'({fa2, fb2}), 32'({fa, fb}));
  endtask

  // One ID slot: comb outputs are checked mid-cycle, the scoreboard entry after the edge.
  task automatic step(input string tag, input logic v, input logic [6:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                      input logic exp_st, input logic [1:0] fa, input logic [1:0] fb);
    ent_t n;
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; ex_flush = fl;
    @(negedge clk);
    check_comb(tag, exp_st, fa, fb);
    if (fl || exp_st) n = '0;
    else begin
      n.e1 = dec(v, op, rd, 1'b1);
      n.e2 = dec(v, op, rd, 1'b0);
    end
    q_ex.push_back(n);
    if (exp_st) begin
      sc1 = (sc1 == 65535) ? sc1 : sc1 + 1;
      sc2 = (sc2 == 3) ? sc2 : sc2 + 1;
    end
    if (fl) begin
      fc1 = (fc1 == 65535) ? fc1 : fc1 + 1;
      fc2 = (fc2 == 3) ? fc2 : fc2 + 1;
    end
    @(posedge clk); #1;
    n = q_ex.pop_front();
    wb1 = mem1; mem1 = ex1; ex1 = n.e1;
    wb2 = mem2; mem2 = ex2; ex2 = n.e2;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    reset = 1'b0; id_valid = 1'b1; id_opcode = R; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    ex_flush = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      q_ex.delete();
      ex1 = '0; mem1 = '0; wb1 = '0; ex2 = '0; mem2 = '0; wb2 = '0;
      sc1 = 0; fc1 = 0; sc2 = 0; fc2 = 0;
      check_regs(tag);
      check_comb(tag, 1'b0, 2'b00, 2'b00);
    end
    reset = 1'b1;
  endtask

  initial begin
    do_reset("reset", 2);
    step("ld5",       1'b1, LW,  5'd1,  5'd0,  5'd5,  1'b0, 1'b0, 2'b00, 2'b00);
    step("lu_stall",  1'b1, R,   5'd5,  5'd7,  5'd6,  1'b0, 1'b1, 2'b00, 2'b00);
    step("lu_go",     1'b1, R,   5'd5,  5'd7,  5'd6,  1'b0, 1'b0, 2'b00, 2'b00);
    step("add3a",     1'b1, R,   5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 2'b01, 2'b00);
    step("add3b",     1'b1, R,   5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 2'b00, 2'b00);
    step("sub4",      1'b1, R,   5'd3,  5'd3,  5'd4,  1'b0, 1'b0, 2'b00, 2'b00);
    step("x0a",       1'b1, R,   5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 2'b10, 2'b10);
    step("x0b",       1'b1, R,   5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00);
    step("sub9",      1'b1, R,   5'd0,  5'd0,  5'd9,  1'b0, 1'b0, 2'b00, 2'b00);
    step("addi10",    1'b1, I,   5'd9,  5'd0,  5'd10, 1'b0, 1'b0, 2'b00, 2'b00);
    step("ld11",      1'b1, LW,  5'd10, 5'd0,  5'd11, 1'b0, 1'b0, 2'b10, 2'b00);
    step("flush_stl", 1'b1, SW,  5'd11, 5'd11, 5'd0,  1'b1, 1'b1, 2'b10, 2'b00);
    step("sw",        1'b1, SW,  5'd11, 5'd11, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00);
    step("br",        1'b1, BR,  5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 2'b01, 2'b01);
    step("jal",       1'b1, JAL, 5'd0,  5'd0,  5'd1,  1'b0, 1'b0, 2'b00, 2'b00);
    step("jalr",      1'b1, JLR, 5'd1,  5'd0,  5'd2,  1'b0, 1'b0, 2'b00, 2'b00);
    step("lui",       1'b1, LUI, 5'd0,  5'd0,  5'd12, 1'b0, 1'b0, 2'b10, 2'b00);
    step("auipc",     1'b1, AUI, 5'd0,  5'd0,  5'd13, 1'b0, 1'b0, 2'b00, 2'b00);
    step("illegal",   1'b1, 7'b1111111, 5'd0, 5'd0, 5'd14, 1'b0, 1'b0, 2'b00, 2'b00);
    step("bubble",    1'b0, R,   5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("sat_ld",  1'b1, LW,  5'd0,  5'd0,  5'd5,  1'b0, 1'b0,
           (i == 0) ? 2'b00 : 2'b01, (i == 0) ? 2'b00 : 2'b01);
      step("sat_stl", 1'b1, R,   5'd5,  5'd5,  5'd6,  1'b0, 1'b1, 2'b00, 2'b00);
      step("sat_go",  1'b1, R,   5'd5,  5'd5,  5'd6,  1'b0, 1'b0, 2'b00, 2'b00);
    end
    step("pre_rst",   1'b1, LW,  5'd0,  5'd0,  5'd7,  1'b0, 1'b0, 2'b01, 2'b01);
    do_reset("mid_reset", 1);
    step("post_rst",  1'b1, R,   5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 2'b00, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Pipelined successor to the single-cycle opcode controller. It decodes the ID-stage opcode into control signals and carries them through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and stalls, squashes on EX-resolved branch/jump, and generates EX-stage forwarding selects. Saturating stall/flush counters are included for performance bring-up. It sits between the instruction decode stage and the datapath pipeline registers.

Parameters:
REG_W, 5, register-index width
ENABLE_UPPER, 1, 1: decode LUI (0110111) and AUIPC (0010111); 0: treat them as illegal
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low; sampled on clk rising edge
id_valid  in  1  ID-stage instruction is valid
id_opcode  in  7  ID-stage opcode field
id_rs1  in  REG_W  ID source register 1
id_rs2  in  REG_W  ID source register 2
id_rd  in  REG_W  ID destination register
ex_flush  in  1  branch taken or jump resolved in EX; squash younger instruction
stall  out  1  combinational; hold PC and IF/ID
ex_alusrc  out  1  EX: 1 = immediate operand
ex_aluop  out  2  EX: 00 ld/st/jalr, 01 branch, 10 R/I arithmetic, 11 upper-immediate
ex_branch  out  1  EX: conditional branch
ex_jal  out  1  EX: JAL
ex_jalr  out  1  EX: JALR
ex_illegal  out  1  EX: valid instruction with undecoded opcode
fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  same for operand B
mem_memread  out  1  MEM: load
mem_memwrite  out  1  MEM: store
mem_rd  out  REG_W  MEM destination
wb_regwrite  out  1  WB: write register file
wb_memtoreg  out  1  WB: 1 = memory data
wb_rd  out  REG_W  WB destination
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Decode (comb, ID). Every field not listed is 0.
  - R 0110011: aluop 10, regwrite, uses rs1/rs2.
  - I 0010011: alusrc, aluop 10, regwrite, uses rs1.
  - LW 0000011: alusrc, memread, memtoreg, regwrite, aluop 00, uses rs1.
  - SW 0100011: alusrc, memwrite, uses rs1/rs2.
  - BR 1100011: branch, aluop 01, uses rs1/rs2.
  - JAL 1101111: jal, regwrite.
  - JALR 1100111: jalr, alusrc, regwrite, uses rs1.
  - LUI/AUIPC (only when ENABLE_UPPER=1): alusrc, aluop 11, regwrite.
  - Any other opcode: all controls 0, illegal=1.
  - regwrite is forced to 0 when id_rd==0. id_valid=0 produces an all-zero bubble.
- Hazard (comb): stall=1 iff id_valid, EX holds a load, ex_rd!=0, and ((uses_rs1 && ex_rd==id_rs1) || (uses_rs2 && ex_rd==id_rs2)).
- ID/EX update every cycle:
  - ex_flush=1: load a bubble (flush has priority over stall).
  - else stall=1: load a bubble. Upstream holds ID, so the instruction re-decodes next cycle.
  - else: load the decoded bundle plus rs1/rs2/rd.
- EX/MEM and MEM/WB always advance, never stall. The EX instruction that raises ex_flush itself proceeds.
- Forwarding (comb, per operand, using EX rs1/rs2):
  - 10 if mem regwrite && mem_rd!=0 && mem_rd==ex_rs; else
  - 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs; else
  - 00. EX/MEM wins when both match.
- Latency: ID decode appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Counters: +1 per cycle with stall=1 (resp. ex_flush=1), saturating at all-ones. Both can count in the same cycle.
- Reset (reset=0 at edge): all pipeline registers become bubbles; every registered output, rd field and counter is 0; fwd_a=fwd_b=00, stall=0. Reset mid-stream discards all in-flight instructions.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid R-type at ID -> all outputs 0, counters 0.
- Decode/latency: LW rd=5 at ID -> ex_alusrc=1, ex_aluop=00 at +1; mem_memread=1, mem_rd=5 at +2; wb_regwrite=wb_memtoreg=1, wb_rd=5 at +3.
- Load-use: LW x5 then ADD x6,x5,x7 -> stall=1 for exactly 1 cycle, EX bubble; ADD enters EX next cycle with fwd_a=01; stall_cnt=1.
- Forward priority: ADD x3, ADD x3, SUB x4,x3,x3 back-to-back -> SUB in EX sees fwd_a=fwd_b=10. Repeat with rd=0 -> fwd=00, wb_regwrite=0.
- Flush vs stall: ex_flush=1 in the same cycle as a load-use condition -> ID/EX loads a bubble; flush_cnt and stall_cnt both +1.
- Illegal/param: opcode 0110111 with ENABLE_UPPER=0 -> ex_illegal=1, regwrite 0. With ENABLE_UPPER=1 -> ex_aluop=11, ex_alusrc=1. Counter saturation at CNT_W=2: 5 stalls -> stall_cnt=3.
